// File: rtl/cc_transi_sequencer.sv
// Timed select sequencer for the transition output mux: on start it walks
// TRANSI1..TRANSI3, each held STEPS frames of STEP_CYCLES clocks, then pulses done.
module cc_transi_sequencer #(
  parameter int SELECTWIDTH = 2,
  parameter int CYCLEWIDTH  = 24,
  parameter int STEP_CYCLES = 12_500_000,
  parameter int STEPWIDTH   = 3,
  parameter int STEPS       = 8
) (
  input  logic                   CC_TRANSEQ_CLOCK_50,
  input  logic                   CC_TRANSEQ_RESET_InLow,
  input  logic                   CC_TRANSEQ_start_In,
  input  logic                   CC_TRANSEQ_abort_In,
  output logic [SELECTWIDTH-1:0] CC_TRANSEQ_select_OutBUS,
  output logic [STEPWIDTH-1:0]   CC_TRANSEQ_step_OutBUS,
  output logic                   CC_TRANSEQ_busy_Out,
  output logic                   CC_TRANSEQ_done_Out
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_DONE} state_e;

  localparam logic [CYCLEWIDTH-1:0] CYC_LAST  = CYCLEWIDTH'(STEP_CYCLES - 1);
  localparam logic [STEPWIDTH-1:0]  STEP_LAST = STEPWIDTH'(STEPS - 1);

  state_e                 state_q, state_d;
  logic [CYCLEWIDTH-1:0]  cyc_q, cyc_d;
  logic [STEPWIDTH-1:0]   step_q, step_d;
  logic [SELECTWIDTH-1:0] select_q, select_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_ff @(posedge CC_TRANSEQ_CLOCK_50 or negedge CC_TRANSEQ_RESET_InLow) begin
    if (!CC_TRANSEQ_RESET_InLow) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      step_q   <= '0;
      select_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      step_q   <= step_d;
      select_q <= select_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state and frame counters; abort overrides everything.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    step_d  = step_q;
    if (CC_TRANSEQ_abort_In) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CC_TRANSEQ_start_In) begin
            state_d = S_T1;
            cyc_d   = '0;
            step_d  = '0;
          end
        end
        S_T1, S_T2, S_T3: begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            if (step_q == STEP_LAST) begin
              step_d = '0;
              case (state_q)
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                default: state_d = S_DONE;
              endcase
            end else begin
              step_d = step_q + STEPWIDTH'(1);
            end
          end else begin
            cyc_d = cyc_q + CYCLEWIDTH'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cyc_d   = '0;
          step_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    select_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_T1: begin
        select_d = SELECTWIDTH'(1);
        busy_d   = 1'b1;
      end
      S_T2: begin
        select_d = SELECTWIDTH'(2);
        busy_d   = 1'b1;
      end
      S_T3: begin
        select_d = SELECTWIDTH'(3);
        busy_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign CC_TRANSEQ_select_OutBUS = select_q;
  assign CC_TRANSEQ_step_OutBUS   = step_q;
  assign CC_TRANSEQ_busy_Out      = busy_q;
  assign CC_TRANSEQ_done_Out      = done_q;

endmodule

// File: tb/tb_cc_transi_sequencer.sv
// Bench for cc_transi_sequencer: elapsed-time reference model checked every cycle,
// plus directed scenarios pinned with hand-computed counts.
module tb_cc_transi_sequencer;

  localparam int SC = 3;
  localparam int ST = 4;
  localparam int PH = SC * ST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] sel;
  logic [1:0] step;
  logic       busy;
  logic       done;

  cc_transi_sequencer #(
    .SELECTWIDTH(2), .CYCLEWIDTH(2), .STEP_CYCLES(SC), .STEPWIDTH(2), .STEPS(ST)
  ) dut (
    .CC_TRANSEQ_CLOCK_50     (clk),
    .CC_TRANSEQ_RESET_InLow  (rst_n),
    .CC_TRANSEQ_start_In     (start),
    .CC_TRANSEQ_abort_In     (abort),
    .CC_TRANSEQ_select_OutBUS(sel),
    .CC_TRANSEQ_step_OutBUS  (step),
    .CC_TRANSEQ_busy_Out     (busy),
    .CC_TRANSEQ_done_Out     (done)
  );

  always #5 clk = ~clk;

  // Reference: mode 0 idle, 1 running (t = clocks elapsed since start), 2 done.
  int mode = 0;
  int t = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 0;
      t    <= 0;
    end else if (abort) begin
      mode <= 0;
      t    <= 0;
    end else begin
      case (mode)
        0: if (start) begin mode <= 1; t <= 0; end
        1: if (t == 3 * PH - 1) mode <= 2; else t <= t + 1;
        default: mode <= 0;
      endcase
    end
  end

  int cyc_n = 0;
  int cyc_bad = 0;
  always @(negedge clk) begin
    int es, ep;
    logic eb, ed;
    es = (mode == 1) ? t / PH + 1 : 0;
    ep = (mode == 1) ? (t % PH) / SC : 0;
    eb = (mode == 1);
    ed = (mode == 2);
    cyc_n <= cyc_n + 1;
    if (int'(sel) != es || int'(step) != ep || busy !== eb || done !== ed) begin
      cyc_bad <= cyc_bad + 1;
      $display("FAIL cycle_check @%0t: sel/step/busy/done got %0d/%0d/%b/%b expected %0d/%0d/%b/%b",
               $time, sel, step, busy, done, es, ep, eb, ed);
    end
  end

  // Running tallies the directed scenarios snapshot and difference.
  int busy_cnt = 0;
  int done_cnt = 0;
  int after_done = 9;
  int gap_sel [2];
  int t1_n = 0;
  int t1_log [4096];
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) begin
      done_cnt   <= done_cnt + 1;
      after_done <= 0;
    end else if (after_done < 2) begin
      gap_sel[after_done] <= int'(sel);
      after_done <= after_done + 1;
    end
    if (sel == 2'd1 && t1_n < 4096) begin
      t1_log[t1_n] <= int'(step);
      t1_n <= t1_n + 1;
    end
  end

  int lit_n = 0;
  int lit_bad = 0;
  task automatic lit(input string name, input int act, input int exp);
    lit_n++;
    if (act != exp) begin
      lit_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic a);
    @(negedge clk);
    #1;
    start = s;
    abort = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  int b0, d0, s0;

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_outputs", {30'd0, sel} + int'(step) + int'(busy) + int'(done), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    b0 = busy_cnt; d0 = done_cnt;
    idle(50);
    lit("idle50_busy", busy_cnt - b0, 0);
    lit("idle50_done", done_cnt - d0, 0);

    // Single start pulse: full sequence and T1 step pattern.
    cyc(1'b1, 1'b0);
    b0 = busy_cnt; d0 = done_cnt; s0 = t1_n;
    idle(40);
    lit("run_busy_cycles", busy_cnt - b0, 36);
    lit("run_done_pulses", done_cnt - d0, 1);
    lit("run_t1_cycles", t1_n - s0, 12);
    for (int i = 0; i < 12; i++) lit($sformatf("t1_step[%0d]", i), t1_log[s0 + i], i / 3);

    // Second start during T2 is ignored.
    cyc(1'b1, 1'b0);
    b0 = busy_cnt; d0 = done_cnt;
    idle(14);
    lit("mid_t2_select", int'(sel), 2);
    cyc(1'b1, 1'b0);
    idle(26);
    lit("restart_busy_cycles", busy_cnt - b0, 36);
    lit("restart_done_pulses", done_cnt - d0, 1);

    // Abort on the 5th cycle of T3.
    cyc(1'b1, 1'b0);
    b0 = busy_cnt; d0 = done_cnt;
    idle(28);
    lit("pre_abort_select", int'(sel), 3);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    lit("post_abort_select", int'(sel), 0);
    lit("post_abort_busy", int'(busy), 0);
    idle(5);
    lit("abort_busy_cycles", busy_cnt - b0, 29);
    lit("abort_done_pulses", done_cnt - d0, 0);
    cyc(1'b1, 1'b0);
    b0 = busy_cnt; d0 = done_cnt;
    idle(40);
    lit("after_abort_busy", busy_cnt - b0, 36);
    lit("after_abort_done", done_cnt - d0, 1);

    // start+abort together in IDLE, then start held high.
    b0 = busy_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    idle(3);
    lit("start_abort_busy", busy_cnt - b0, 0);
    b0 = busy_cnt; d0 = done_cnt;
    for (int i = 0; i < 80; i++) cyc(1'b1, 1'b0);
    lit("held_done_pulses", done_cnt - d0, 2);
    lit("held_gap_select0", gap_sel[0], 0);
    lit("held_gap_select1", gap_sel[1], 1);
    idle(45);
    lit("held_busy_total", busy_cnt - b0, 108);
    lit("held_done_total", done_cnt - d0, 3);

    // Asynchronous reset in the middle of T2.
    cyc(1'b1, 1'b0);
    idle(15);
    lit("pre_reset_select", int'(sel), 2);
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset_select", int'(sel), 0);
    lit("async_reset_busy", int'(busy), 0);
    lit("async_reset_step", int'(step), 0);
    idle(2);
    rst_n = 1'b1;
    b0 = busy_cnt;
    idle(20);
    lit("post_reset_idle_busy", busy_cnt - b0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 79) == 0));
    idle(45);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cyc_n + lit_n, cyc_bad + lit_bad);
    $finish;
  end

endmodule
